sram_sprite_reader: RTL and testbench

- Read-side initiator for the single-port block-RAM image stores (sprite/background SRAMs with 1-cycle registered read).
- On `start`, walks a rectangular sub-image (base, width, height, row stride) and drives SRAM `en`/`addr`.
- Absorbs the SRAM's 1-cycle read latency and streams pixels out on a valid/ready interface toward the animation compositor / line buffer.
- Sustains 1 pixel/cycle under continuous `ready`.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sram_sprite_reader_if.sv | 42 ++++
 rtl/pix_skid_fifo.sv | 47 ++++
 rtl/sram_sprite_reader.sv | 147 ++++++++++++++
 tb/tb_sram_sprite_reader.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite SRAM read path: FSM states,
// pixel FIFO geometry and the default pixel/address widths and colour key.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam int PIX_W_DEF  = 12;
  localparam int ADDR_W_DEF = 16;
  localparam int DIM_W_DEF  = 8;

  localparam logic [PIX_W_DEF-1:0] COLOR_KEY_DEF = 12'h0F0;

endpackage

// File: rtl/sram_sprite_reader_if.sv
// Control, SRAM read port and pixel stream of the sprite reader in one bundle;
// master is the reader itself, slave is the SRAM/compositor/sequencer side.
interface sram_sprite_reader_if
  import sprite_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DIM_W      = DIM_W_DEF
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [DIM_W-1:0]      img_w;
  logic [DIM_W-1:0]      img_h;
  logic [DIM_W-1:0]      stride;
  logic                  busy;
  logic                  done;

  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_data;

  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_last;
  logic                  pix_eof;
  logic                  pix_key;

  modport master (
    input  start, base_addr, img_w, img_h, stride, sram_data, pix_ready,
    output busy, done, sram_en, sram_we, sram_addr,
           pix_data, pix_valid, pix_last, pix_eof, pix_key
  );

  modport slave (
    output start, base_addr, img_w, img_h, stride, sram_data, pix_ready,
    input  busy, done, sram_en, sram_we, sram_addr,
           pix_data, pix_valid, pix_last, pix_eof, pix_key
  );

endinterface

// File: rtl/pix_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs the SRAM read latency; head entry is
// presented combinationally. Single-bit pointers assume FIFO_DEPTH == 2.
module pix_skid_fifo
  import sprite_pkg::*;
#(
  parameter int WIDTH = PIX_W_DEF + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the storage is cleared too (only two words) so pix_data reads
      // zero straight out of reset instead of stale pixels.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/sram_sprite_reader.sv
// Walks a rectangular sub-image in a 1-cycle-latency SRAM and streams pixels
// out on valid/ready. Define SRAM_READER_COLORKEY_EN to flag COLOR_KEY pixels.
module sram_sprite_reader
  import sprite_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DIM_W      = DIM_W_DEF
`ifdef SRAM_READER_COLORKEY_EN
  ,
  parameter logic [DATA_WIDTH-1:0] COLOR_KEY = COLOR_KEY_DEF
`endif
) (
  input logic                  clk,
  input logic                  reset,
  sram_sprite_reader_if.master bus
);

`ifdef SRAM_READER_COLORKEY_EN
  localparam int FLAG_W = 3;
`else
  localparam int FLAG_W = 2;
`endif
  localparam int PAY_W = DATA_WIDTH + FLAG_W;

  state_e                state;
  logic [DIM_W-1:0]      w_q, h_q, stride_q;
  logic [DIM_W-1:0]      col, row;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  busy_q, done_q;
  logic                  inflight, infl_last, infl_eof;

  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [PAY_W-1:0]      fifo_wdata, fifo_head;
  logic                  pix_valid, pop, issue, drain_complete;
  logic                  col_last, row_last;
  logic [2:0]            occupancy;
  logic [ADDR_WIDTH-1:0] cur_addr;

  assign pix_valid = (fifo_count != '0);
  assign pop       = pix_valid && bus.pix_ready;
  assign occupancy = 3'(fifo_count) + 3'(inflight);
  // Credit counts the slot freed by this cycle's pop, keeping 1 pixel/cycle.
  assign issue     = (state == ST_FETCH) && (occupancy < (3'd2 + 3'(pop)));
  assign cur_addr  = row_base + ADDR_WIDTH'(col);
  assign col_last  = (col == w_q - DIM_W'(1));
  assign row_last  = (row == h_q - DIM_W'(1));

  assign drain_complete = !inflight &&
                          ((fifo_count == '0) || ((fifo_count == FIFO_CNT_W'(1)) && pop));

`ifdef SRAM_READER_COLORKEY_EN
  assign fifo_wdata = {(bus.sram_data == COLOR_KEY), infl_eof, infl_last, bus.sram_data};
  assign bus.pix_key = fifo_head[DATA_WIDTH+2];
`else
  assign fifo_wdata = {infl_eof, infl_last, bus.sram_data};
  assign bus.pix_key = 1'b0;
`endif

  pix_skid_fifo #(.WIDTH(PAY_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  assign bus.pix_data  = fifo_head[DATA_WIDTH-1:0];
  assign bus.pix_last  = fifo_head[DATA_WIDTH];
  assign bus.pix_eof   = fifo_head[DATA_WIDTH+1];
  assign bus.pix_valid = pix_valid;
  assign bus.sram_en   = issue;
  assign bus.sram_we   = 1'b0;
  assign bus.sram_addr = issue ? cur_addr : last_addr;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      stride_q  <= '0;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      last_addr <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      inflight  <= 1'b0;
      infl_last <= 1'b0;
      infl_eof  <= 1'b0;
    end else begin
      inflight  <= issue;
      infl_last <= issue && col_last;
      infl_eof  <= issue && col_last && row_last;
      if (issue) last_addr <= cur_addr;

      unique case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            w_q      <= bus.img_w;
            h_q      <= bus.img_h;
            stride_q <= bus.stride;
            col      <= '0;
            row      <= '0;
            row_base <= bus.base_addr;
            busy_q   <= 1'b1;
            state    <= ((bus.img_w == '0) || (bus.img_h == '0)) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            if (col_last) begin
              col      <= '0;
              row      <= row + DIM_W'(1);
              row_base <= row_base + ADDR_WIDTH'(stride_q);
              if (row_last) state <= ST_DRAIN;
            end else begin
              col <= col + DIM_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // done rises as the final pixel handshakes, so it lands one cycle later.
          if (drain_complete) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // An empty job enters with done low and pulses on the way out.
          done_q <= !done_q;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_sprite_reader.sv
// Directed bench for sram_sprite_reader: address walk, latency, ready stalls,
// empty jobs, address wrap, mid-job reset and colour-key flagging.
module tb_sram_sprite_reader;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_sprite_reader_if bus ();

  sram_sprite_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] data;
    logic        last;
    logic        eof;
    logic        key;
    int          cyc;
  } beat_t;

  beat_t       beats[$];
  logic [15:0] addrs[$];
  int          addr_cyc[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          done_cyc, done_cnt, credit_err, hold_err, valid_err, busy_err;

  // Image store contents: address-derived pattern with a transparent pixel at 0x0101.
  function automatic logic [11:0] exp_pix(input logic [15:0] a);
    if (a == 16'h0101) return 12'h0F0;
    return a[11:0] ^ 12'h5A5;
  endfunction

  function automatic logic exp_key(input logic [11:0] d);
`ifdef SRAM_READER_COLORKEY_EN
    return (d == 12'h0F0);
`else
    return (d == 12'hFFF) && 1'b0;
`endif
  endfunction

  // Behavioural single-port SRAM with 1-cycle registered read.
  always @(posedge clk) if (bus.sram_en) bus.sram_data <= exp_pix(bus.sram_addr);

  task automatic run_job(input logic [15:0] base, input logic [7:0] w, input logic [7:0] h,
                         input logic [7:0] stride, input int mode, input int budget);
    int cnt, infl, pop, prev_stall;
    logic [11:0] p_data;
    logic p_last, p_eof, p_key;
    beat_t b;
    beats.delete(); addrs.delete(); addr_cyc.delete();
    done_cyc = -1; done_cnt = 0; credit_err = 0; hold_err = 0; valid_err = 0; busy_err = 0;
    cnt = 0; infl = 0; prev_stall = 0;
    p_data = '0; p_last = 1'b0; p_eof = 1'b0; p_key = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = base; bus.img_w = w; bus.img_h = h; bus.stride = stride;
    bus.pix_ready = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.pix_ready = (mode == 0) ? 1'b1 : ((k % 3) == 1);
      #1;
      pop = int'(bus.pix_valid && bus.pix_ready);
      if (bus.pix_valid !== (cnt != 0)) valid_err++;
      if (bus.sram_en && (cnt + infl - pop >= 2)) credit_err++;
      if (prev_stall != 0 && (bus.pix_valid !== 1'b1 || bus.pix_data !== p_data ||
          bus.pix_last !== p_last || bus.pix_eof !== p_eof || bus.pix_key !== p_key)) hold_err++;
      if (bus.sram_en) begin addrs.push_back(bus.sram_addr); addr_cyc.push_back(k); end
      if (pop != 0) begin
        b.data = bus.pix_data; b.last = bus.pix_last; b.eof = bus.pix_eof;
        b.key = bus.pix_key; b.cyc = k;
        beats.push_back(b);
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
        if (bus.busy !== 1'b0) busy_err++;
      end else if (done_cyc < 0 && bus.busy !== 1'b1) busy_err++;
      cnt = cnt + infl - pop;
      infl = int'(bus.sram_en);
      prev_stall = int'(bus.pix_valid && !bus.pix_ready);
      p_data = bus.pix_data; p_last = bus.pix_last; p_eof = bus.pix_eof; p_key = bus.pix_key;
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
    end
    n_vec++;
    if (done_cyc < 0) begin
      n_miss++;
      $display("FAIL job_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.img_w = '0; bus.img_h = '0; bus.stride = '0;
    bus.pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.sram_en, bus.sram_we, bus.sram_addr, bus.pix_valid,
         bus.pix_data, bus.pix_last, bus.pix_eof, bus.pix_key} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: got busy=%b done=%b en=%b addr=%h valid=%b data=%h want all 0",
               bus.busy, bus.done, bus.sram_en, bus.sram_addr, bus.pix_valid, bus.pix_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic(input bit toggle);
    logic [15:0] exp_a [8];
    string tag;
    exp_a = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0110, 16'h0111, 16'h0112, 16'h0113};
    tag = toggle ? "toggle" : "basic";
    run_job(16'h0100, 8'd4, 8'd2, 8'd16, toggle ? 1 : 0, 120);
    n_vec++;
    if (addrs.size() != 8 || beats.size() != 8) begin
      n_miss++;
      $display("FAIL %s_counts: got %0d addrs %0d pixels want 8/8", tag, addrs.size(), beats.size());
    end
    for (int i = 0; i < 8 && i < addrs.size(); i++) begin
      n_vec++;
      if (addrs[i] !== exp_a[i] || (!toggle && addr_cyc[i] != i + 1)) begin
        n_miss++;
        $display("FAIL %s_addr%0d: got %h@%0d want %h@%0d", tag, i, addrs[i], addr_cyc[i], exp_a[i], i + 1);
      end
    end
    for (int i = 0; i < 8 && i < beats.size(); i++) begin
      n_vec++;
      if (beats[i].data !== exp_pix(exp_a[i]) || beats[i].last !== (i % 4 == 3) ||
          beats[i].eof !== (i == 7) || beats[i].key !== exp_key(exp_pix(exp_a[i]))) begin
        n_miss++;
        $display("FAIL %s_pix%0d: got d=%h l=%b e=%b k=%b want d=%h l=%b e=%b k=%b", tag, i,
                 beats[i].data, beats[i].last, beats[i].eof, beats[i].key, exp_pix(exp_a[i]),
                 (i % 4 == 3), (i == 7), exp_key(exp_pix(exp_a[i])));
      end
    end
    if (!toggle && beats.size() > 0) begin
      n_vec++;
      if (beats[0].cyc != 3) begin
        n_miss++;
        $display("FAIL basic_first_valid: got cycle %0d want 3", beats[0].cyc);
      end
    end
    if (beats.size() == 8) begin
      n_vec++;
      if (done_cyc != beats[7].cyc + 1 || done_cnt != 1) begin
        n_miss++;
        $display("FAIL %s_done: got cycle %0d count %0d want cycle %0d count 1",
                 tag, done_cyc, done_cnt, beats[7].cyc + 1);
      end
    end
    n_vec++;
    if (credit_err != 0 || hold_err != 0 || valid_err != 0 || busy_err != 0) begin
      n_miss++;
      $display("FAIL %s_protocol: got credit=%0d hold=%0d valid=%0d busy=%0d want all 0",
               tag, credit_err, hold_err, valid_err, busy_err);
    end
  endtask

  task automatic test_zero_size();
    run_job(16'h0040, 8'd0, 8'd5, 8'd3, 0, 20);
    n_vec++;
    if (addrs.size() != 0 || beats.size() != 0 || done_cyc != 2 || done_cnt != 1 || busy_err != 0) begin
      n_miss++;
      $display("FAIL zero_size: got en=%0d pix=%0d done@%0d x%0d busy_err=%0d want 0 0 2 1 0",
               addrs.size(), beats.size(), done_cyc, done_cnt, busy_err);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    run_job(16'hFFFE, 8'd4, 8'd1, 8'd0, 0, 40);
    n_vec++;
    if (addrs.size() != 4 || beats.size() != 4) begin
      n_miss++;
      $display("FAIL wrap_counts: got %0d addrs %0d pixels want 4/4", addrs.size(), beats.size());
    end
    for (int i = 0; i < 4 && i < addrs.size() && i < beats.size(); i++) begin
      n_vec++;
      if (addrs[i] !== exp_a[i] || beats[i].data !== exp_pix(exp_a[i]) ||
          beats[i].last !== (i == 3) || beats[i].eof !== (i == 3)) begin
        n_miss++;
        $display("FAIL wrap_%0d: got a=%h d=%h l=%b e=%b want a=%h d=%h l=%b e=%b", i, addrs[i],
                 beats[i].data, beats[i].last, beats[i].eof, exp_a[i], exp_pix(exp_a[i]), (i == 3), (i == 3));
      end
    end
  endtask

  task automatic test_reset_abort();
    int hs, stray;
    hs = 0; stray = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 16'h0200; bus.img_w = 8'd4; bus.img_h = 8'd4;
    bus.stride = 8'd8; bus.pix_ready = 1'b1;
    for (int k = 1; k <= 40 && hs < 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.pix_valid && bus.pix_ready) hs++;
    end
    n_vec++;
    if (hs != 3) begin
      n_miss++;
      $display("FAIL abort_reach_pixel3: got %0d handshakes want 3", hs);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.busy, bus.done, bus.sram_en, bus.sram_we, bus.sram_addr, bus.pix_valid,
         bus.pix_data, bus.pix_last, bus.pix_eof, bus.pix_key} !== '0) begin
      n_miss++;
      $display("FAIL abort_outputs: got busy=%b done=%b en=%b addr=%h valid=%b data=%h want all 0",
               bus.busy, bus.done, bus.sram_en, bus.sram_addr, bus.pix_valid, bus.pix_data);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (bus.done || bus.sram_en || bus.pix_valid || bus.busy) stray++;
    end
    n_vec++;
    if (stray != 0) begin
      n_miss++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", stray);
    end
    test_basic(1'b0);
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_zero_size();
    test_wrap();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
